// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width, parity-mode encoding and the
// receive-FIFO entry layout (error flag stored alongside the data word).
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_t;

    typedef struct packed {
        logic                       err;
        logic [UART_DATA_WIDTH-1:0] data;
    } uart_entry_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Idle timer for the UART receive FIFO: emits a one-cycle pulse once the FIFO
// has held data untouched for TIMEOUT_CYC cycles, then holds until activity.
module uart_rx_timeout #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic activity,
    input  logic empty,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          timeout_reg;
    logic          timeout_next;

    always_comb begin
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        if (activity || empty) begin
            cnt_next = '0;
        end else if (cnt_reg != CW'(TIMEOUT_CYC)) begin
            cnt_next     = cnt_reg + CW'(1);
            // Pulse only on the transition into the terminal count.
            timeout_next = (cnt_next == CW'(TIMEOUT_CYC));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through, with sticky overrun and fill
// threshold. Idle-timeout pulse is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_error,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_err,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    input  logic [$clog2(DEPTH):0]     thresh,
    output logic                       thresh_hit,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic                       rx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    uart_entry_t   mem [DEPTH];
    uart_entry_t   in_entry;
    uart_entry_t   head_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_inc;
    logic [LW-1:0] level_reg;
    logic          overrun_reg;
    logic          push;
    logic          pop;
    logic          drop;
    logic          head_bypass;

    assign in_entry   = '{err: rx_error, data: rx_data};
    assign empty      = (level_reg == '0);
    assign full       = (level_reg == LW'(DEPTH));
    assign thresh_hit = (thresh != '0) && (level_reg >= thresh);
    assign pop        = rd_en && !empty;
    assign push       = rx_valid && (!full || rd_en);
    assign drop       = rx_valid && full && !rd_en;
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);
    // The incoming word becomes the head when nothing else will be left ahead of it.
    assign head_bypass = push && (empty || (pop && level_reg == LW'(1)));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            head_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (head_bypass) begin
                head_reg <= in_entry;
            end else if (pop) begin
                head_reg <= mem[rd_ptr_inc];
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign rd_data = head_reg.data;
    assign rd_err  = head_reg.err;
    assign level   = level_reg;
    assign overrun = overrun_reg;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .activity(push || pop),
        .empty   (empty),
        .timeout (rx_timeout)
    );
`else
    // Constant 0 for any legal TIMEOUT_CYC; the timer is compiled out.
    assign rx_timeout = (TIMEOUT_CYC < 1);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; the idle-timeout scenario is exercised when
// UART_RX_FIFO_TIMEOUT_EN is defined, otherwise rx_timeout must stay low.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int TCYC  = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_error = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [LW-1:0] thresh = '0;
    logic [DW-1:0] rd_data;
    logic          rd_err;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          thresh_hit;
    logic          overrun;
    logic          rx_timeout;

    int            checks = 0;
    int            fails = 0;
    logic [DW:0]   model_q[$];
    logic          ov_model = 1'b0;
    logic [DW:0]   last_pop = '0;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .thresh     (thresh),
        .thresh_hit (thresh_hit),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus: scoreboard pop check before the edge, flag check after it.
    task automatic do_cycle(input logic v, input logic [DW-1:0] d, input logic e,
                            input logic rd, input logic clr);
        bit            was_full = (model_q.size() == DEPTH);
        bit            do_pop   = rd && (model_q.size() != 0);
        bit            do_push  = v && (!was_full || rd);
        logic [DW:0]   exp_e;
        logic [LW+3:0] act_s;
        logic [LW+3:0] exp_s;
        rx_valid    = v;
        rx_data     = d;
        rx_error    = e;
        rd_en       = rd;
        clr_overrun = clr;
        if (do_pop) begin
            exp_e = model_q.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp_e) begin
                fails++;
                $display("FAIL pop_data: got err=%0b data=0x%02h, expected err=%0b data=0x%02h",
                         rd_err, rd_data, exp_e[DW], exp_e[DW-1:0]);
            end
            last_pop = exp_e;
        end
        if (do_push) model_q.push_back({e, d});
        if (v && was_full && !rd) ov_model = 1'b1;
        else if (clr)             ov_model = 1'b0;
        tick();
        rx_valid    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        act_s = {level, empty, full, overrun, thresh_hit};
        exp_s = {LW'(model_q.size()), model_q.size() == 0, model_q.size() == DEPTH, ov_model,
                 (thresh != '0) && (model_q.size() >= int'(thresh))};
        checks++;
        if (act_s !== exp_s) begin
            fails++;
            $display("FAIL status: got level=%0d empty=%0b full=%0b ovr=%0b thit=%0b, expected level=%0d empty=%0b full=%0b ovr=%0b thit=%0b",
                     act_s[LW+3:4], act_s[3], act_s[2], act_s[1], act_s[0],
                     exp_s[LW+3:4], exp_s[3], exp_s[2], exp_s[1], exp_s[0]);
        end
`ifndef UART_RX_FIFO_TIMEOUT_EN
        checks++;
        if (rx_timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_tied: got rx_timeout=%0b, expected 0", rx_timeout);
        end
`endif
        $display("t=%0t push=%0b pop=%0b din=%0b/0x%02h level=%0d empty=%0b full=%0b ovr=%0b",
                 $time, do_push, do_pop, e, d, level, empty, full, overrun);
    endtask

    task automatic test_reset;
        logic [DW+6:0] act_s;
        rst_n = 1'b0;
        tick();
        tick();
        act_s = {empty, full, overrun, thresh_hit, rx_timeout, rd_err, rd_data, level == '0};
        checks++;
        if (act_s !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got empty=%0b full=%0b ovr=%0b thit=%0b to=%0b err=%0b data=0x%02h level=%0d, expected 1 0 0 0 0 0 0x00 0",
                     empty, full, overrun, thresh_hit, rx_timeout, rd_err, rd_data, level);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        do_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({level, rd_err, rd_data} !== {LW'(2), 1'b0, 8'h55}) begin
            fails++;
            $display("FAIL basic_two: got level=%0d err=%0b data=0x%02h, expected level=2 err=0 data=0x55",
                     level, rd_err, rd_data);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({level, rd_err, rd_data} !== {LW'(1), 1'b1, 8'hA3}) begin
            fails++;
            $display("FAIL basic_pop: got level=%0d err=%0b data=0x%02h, expected level=1 err=1 data=0xa3",
                     level, rd_err, rd_data);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 17; i++) begin
            do_cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            if (i == 15) begin
                checks++;
                if (full !== 1'b1 || overrun !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_full16: got full=%0b ovr=%0b, expected full=1 ovr=0", full, overrun);
                end
            end
        end
        checks++;
        if (overrun !== 1'b1 || level !== LW'(16)) begin
            fails++;
            $display("FAIL ovf_drop: got ovr=%0b level=%0d, expected ovr=1 level=16", overrun, level);
        end
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (last_pop !== {1'b0, 8'h0F}) begin
            fails++;
            $display("FAIL ovf_last: got last popped 0x%03h, expected 0x00f", last_pop);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got ovr=%0b, expected 0", overrun);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 16; i++) do_cycle(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        checks++;
        if (level !== LW'(16) || overrun !== 1'b0) begin
            fails++;
            $display("FAIL fullpp_level: got level=%0d ovr=%0b, expected level=16 ovr=0", level, overrun);
        end
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (last_pop !== {1'b0, 8'h77}) begin
            fails++;
            $display("FAIL fullpp_last: got last popped 0x%03h, expected 0x077", last_pop);
        end
    endtask

    task automatic test_thresh;
        thresh = LW'(4);
        for (int i = 1; i <= 4; i++) begin
            do_cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            checks++;
            if (thresh_hit !== (i == 4)) begin
                fails++;
                $display("FAIL thresh_rise: after push %0d got thit=%0b, expected %0b", i, thresh_hit, i == 4);
            end
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (thresh_hit !== 1'b0) begin
            fails++;
            $display("FAIL thresh_fall: got thit=%0b, expected 0", thresh_hit);
        end
        thresh = '0;
        for (int i = 0; i < 13; i++) do_cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (thresh_hit !== 1'b0 || full !== 1'b1) begin
            fails++;
            $display("FAIL thresh_off: got thit=%0b full=%0b, expected thit=0 full=1", thresh_hit, full);
        end
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 5; i++) do_cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (level !== LW'(5)) begin
            fails++;
            $display("FAIL areset_pre: got level=%0d, expected 5", level);
        end
        #3;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        rst_n    = 1'b0;
        #1;
        checks++;
        if ({level, empty, full, overrun, thresh_hit, rd_err, rd_data} !== {LW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL areset_now: got level=%0d empty=%0b full=%0b ovr=%0b err=%0b data=0x%02h, expected 0 1 0 0 0 0x00",
                     level, empty, full, overrun, rd_err, rd_data);
        end
        tick();
        checks++;
        if (level !== LW'(0) || empty !== 1'b1) begin
            fails++;
            $display("FAIL areset_hold: got level=%0d empty=%0b, expected level=0 empty=1", level, empty);
        end
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        model_q.delete();
        ov_model = 1'b0;
        tick();
        do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rd_data !== 8'h3C || rd_err !== 1'b0) begin
            fails++;
            $display("FAIL areset_after: got err=%0b data=0x%02h, expected err=0 data=0x3c", rd_err, rd_data);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        int pulses = 0;
        int pulse_at = -1;
        do_cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (rx_timeout === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != TCYC) begin
            fails++;
            $display("FAIL timeout_pulse: got %0d pulses at cycle %0d, expected 1 pulse at cycle %0d",
                     pulses, pulse_at, TCYC);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        do_cycle(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            do_cycle(1'b0, 8'h00, 1'b0, k == 50, 1'b0);
            if (rx_timeout === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL timeout_suppress: got %0d pulses, expected 0", pulses);
        end
`else
        do_cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 150; k++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_thresh();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, receive word width; must match uart_rx.
REQ-002 SHALL have parameter DEPTH, 16, entry count; power of two, >=2.
REQ-003 SHALL have parameter TIMEOUT_CYC, 4096, idle clk cycles before rx_timeout; >=1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data  input  DATA_WIDTH  received word from the receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle push strobe from the receiver.
REQ-008 SHALL have port rx_error  input  1  parity/frame error flag qualified by rx_valid.
REQ-009 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-010 SHALL have port rd_data  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-011 SHALL have port rd_err  output  1  error flag stored with the head word.
REQ-012 SHALL have port empty  output  1  no entries.
REQ-013 SHALL have port full  output  1  DEPTH entries.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-015 SHALL have port thresh  input  $clog2(DEPTH)+1  fill threshold; 0 disables.
REQ-016 SHALL have port thresh_hit  output  1  level >= thresh and thresh != 0.
REQ-017 SHALL have port overrun  output  1  sticky overflow flag.
REQ-018 SHALL have port clr_overrun  input  1  clears overrun.
REQ-019 SHALL have port rx_timeout  output  1  one-cycle idle-timeout pulse (macro-dependent).

Function
REQ-020 SHALL store {rx_error, rx_data} per entry. Push occurs when rx_valid=1 and (full=0 or rd_en=1).
REQ-021 SHALL present a pushed word on rd_data/rd_err and deassert empty on the cycle after the push edge. This is a 1-cycle latency.
REQ-022 SHALL pop on the rising edge when rd_en=1 and empty=0. rd_data SHALL show the next entry the following cycle. rd_en while empty is ignored, with no state change.
REQ-023 SHALL, on a simultaneous push and pop (including while full), perform both and leave level unchanged.
REQ-024 SHALL drop rx_valid while full without a pop, leave contents unchanged and set overrun on the next edge.
REQ-025 SHALL wrap read/write pointers modulo DEPTH. level SHALL equal write count minus read count, in range 0..DEPTH.
REQ-026 SHALL derive empty, full and thresh_hit combinationally from the registered level.
REQ-027 SHALL keep overrun set when clr_overrun and a new overflow occur in the same cycle (set wins).
REQ-028 SHALL leave rd_data as don't-care while empty. The bench must not check it.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-push, asynchronously force: pointers and level to 0, empty=1, full=0, thresh_hit=0, overrun=0, rx_timeout=0, timeout counter to 0, and rd_data/rd_err to 0.
REQ-030 SHALL treat stored entries as discarded after reset.

Configuration
REQ-031 SHALL compile the idle-timeout feature only when UART_RX_FIFO_TIMEOUT_EN is defined.
REQ-032 With the macro defined:
- the counter SHALL clear on any push or pop, or when empty=1;
- the counter SHALL increment otherwise;
- rx_timeout SHALL pulse for one cycle when the count reaches TIMEOUT_CYC, then the counter holds until the next push/pop.
REQ-033 Without the macro, rx_timeout SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-034 SHALL take the shared UART package (uart_pkg) entry typedef (error bit + data), DATA_WIDTH default and parity-mode encoding from that package.
REQ-035 SHALL place the timeout counter in sub-module uart_rx_timeout, instantiated only under UART_RX_FIFO_TIMEOUT_EN. Storage and pointers SHALL stay in uart_rx_fifo.

Verification
REQ-036 Push 0x55 (err=0) then 0xA3 (err=1), no rd_en -> level=2, rd_data=0x55, rd_err=0; after one pop rd_data=0xA3, rd_err=1, level=1.
REQ-037 Push 17 words 0x00..0x10 into DEPTH=16 -> full=1 after 16 pushes, 0x10 dropped, overrun=1; drain reads 0x00..0x0F in order; clr_overrun -> overrun=0.
REQ-038 At full, push 0x77 with rd_en=1 same cycle -> level stays 16, overrun=0, 0x77 is the last word read.
REQ-039 thresh=4: pushes 1..4 -> thresh_hit rises the cycle after the 4th push; one pop -> falls; thresh=0 -> thresh_hit=0 at any level.
REQ-040 Pulse rst_n low mid-stream with level=5 -> level=0 and empty=1 immediately; next push 0x3C reads back 0x3C.
REQ-041 With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYC=100, push 1 word then idle -> exactly one rx_timeout pulse 100 cycles after the push; a pop before cycle 100 suppresses it.
